// File: rtl/spike_window_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : spike_window_sequencer
// Brief    : Detects rising threshold crossings and streams a fixed-length
//            sample window into an external accumulator. Captures the
//            accumulator's sum as one feature word per spike.
// Revision : 1.0 - initial release
//==============================================================================
module spike_window_sequencer #(
    parameter int SAMPLE_WIDTH = 14,
    parameter int WINDOW_LEN   = 8,
    parameter int HOLDOFF_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [SAMPLE_WIDTH-1:0] threshold,
    output logic                    acc_load,
    output logic [SAMPLE_WIDTH-1:0] acc_a,
    input  logic [SAMPLE_WIDTH:0]   acc_y,
    input  logic                    acc_overflow,
    output logic                    feature_valid,
    output logic [SAMPLE_WIDTH:0]   feature,
    output logic                    feature_overflow,
    output logic                    busy
);

    localparam logic [7:0] C_WINDOW_LEN  = 8'(WINDOW_LEN);
    localparam logic [7:0] C_HOLDOFF_LEN = 8'(HOLDOFF_LEN);
    localparam bit         C_HAS_HOLDOFF = (HOLDOFF_LEN != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_count;
    logic [7:0]              w_count_nxt;
    logic [7:0]              r_hold;
    logic [7:0]              w_hold_nxt;
    logic                    r_prev_above;
    logic                    w_prev_above_nxt;
    logic                    r_ovf_sticky;
    logic                    w_ovf_sticky_nxt;
    logic                    r_acc_load;
    logic                    w_acc_load_nxt;
    logic [SAMPLE_WIDTH-1:0] r_acc_a;
    logic [SAMPLE_WIDTH-1:0] w_acc_a_nxt;
    logic                    r_feature_valid;
    logic                    w_feature_valid_nxt;
    logic [SAMPLE_WIDTH:0]   r_feature;
    logic [SAMPLE_WIDTH:0]   w_feature_nxt;
    logic                    r_feature_overflow;
    logic                    w_feature_overflow_nxt;
    logic                    r_busy;

    logic                    w_above;
    logic                    w_trigger;

    assign w_above   = ($signed(sample) >= $signed(threshold));
    assign w_trigger = sample_valid && w_above && !r_prev_above;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_count            <= 8'd0;
            r_hold             <= 8'd0;
            r_prev_above       <= 1'b1;
            r_ovf_sticky       <= 1'b0;
            r_acc_load         <= 1'b0;
            r_acc_a            <= '0;
            r_feature_valid    <= 1'b0;
            r_feature          <= '0;
            r_feature_overflow <= 1'b0;
            r_busy             <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_count            <= w_count_nxt;
            r_hold             <= w_hold_nxt;
            r_prev_above       <= w_prev_above_nxt;
            r_ovf_sticky       <= w_ovf_sticky_nxt;
            r_acc_load         <= w_acc_load_nxt;
            r_acc_a            <= w_acc_a_nxt;
            r_feature_valid    <= w_feature_valid_nxt;
            r_feature          <= w_feature_nxt;
            r_feature_overflow <= w_feature_overflow_nxt;
            r_busy             <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        w_count_nxt            = r_count;
        w_hold_nxt             = r_hold;
        w_ovf_sticky_nxt       = r_ovf_sticky;
        w_acc_load_nxt         = 1'b0;
        w_acc_a_nxt            = '0;
        w_feature_valid_nxt    = 1'b0;
        w_feature_nxt          = r_feature;
        w_feature_overflow_nxt = r_feature_overflow;
        w_prev_above_nxt       = sample_valid ? w_above : r_prev_above;

        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_acc_load_nxt   = 1'b1;
                    w_acc_a_nxt      = sample;
                    w_count_nxt      = 8'd1;
                    w_ovf_sticky_nxt = 1'b0;
                    w_state_nxt      = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                // On the load cycle acc_overflow still belongs to the previous window.
                if (!r_acc_load) begin
                    w_ovf_sticky_nxt = r_ovf_sticky | acc_overflow;
                end
                // A full count means the last sample is on acc_a now; its sum
                // lands in acc_y during the following DRAIN cycle.
                if (r_count == C_WINDOW_LEN) begin
                    w_state_nxt = ST_DRAIN;
                end else if (sample_valid) begin
                    w_acc_a_nxt = sample;
                    w_count_nxt = r_count + 8'd1;
                end
            end

            ST_DRAIN: begin
                w_feature_nxt          = acc_y;
                w_feature_overflow_nxt = r_ovf_sticky | acc_overflow;
                w_feature_valid_nxt    = 1'b1;
                w_hold_nxt             = 8'd1;
                w_state_nxt            = C_HAS_HOLDOFF ? ST_HOLDOFF : ST_IDLE;
            end

            ST_HOLDOFF: begin
                if (r_hold >= C_HOLDOFF_LEN) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign acc_load         = r_acc_load;
    assign acc_a            = r_acc_a;
    assign feature_valid    = r_feature_valid;
    assign feature          = r_feature;
    assign feature_overflow = r_feature_overflow;
    assign busy             = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spike_window_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_spike_window_sequencer
// Brief    : Table-driven bench with a behavioural accumulator model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_spike_window_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [13:0] sample = '0;
    logic [13:0] threshold = 14'd100;
    logic        acc_load;
    logic [13:0] acc_a;
    logic [14:0] acc_y = 15'h1234;
    logic        acc_overflow = 1'b1;
    logic        feature_valid;
    logic [14:0] feature;
    logic        feature_overflow;
    logic        busy;

    spike_window_sequencer #(
        .SAMPLE_WIDTH(14),
        .WINDOW_LEN  (8),
        .HOLDOFF_LEN (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_valid    (sample_valid),
        .sample          (sample),
        .threshold       (threshold),
        .acc_load        (acc_load),
        .acc_a           (acc_a),
        .acc_y           (acc_y),
        .acc_overflow    (acc_overflow),
        .feature_valid   (feature_valid),
        .feature         (feature),
        .feature_overflow(feature_overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Downstream accumulator: adds acc_a every clock, 15-bit wrap, per-add overflow.
    logic [15:0] m_sum;
    assign m_sum = {acc_y[14], acc_y} + {{2{acc_a[13]}}, acc_a};
    always @(posedge clk) begin
        if (acc_load) begin
            acc_y        <= {acc_a[13], acc_a};
            acc_overflow <= 1'b0;
        end else begin
            acc_y        <= m_sum[14:0];
            acc_overflow <= m_sum[15] ^ m_sum[14];
        end
    end

    int n_pulse = 0;
    always @(posedge clk) begin
        if (feature_valid === 1'b1) n_pulse <= n_pulse + 1;
    end

    typedef struct {
        string       tag;
        logic        rst;
        logic        v;
        logic [13:0] s;
        logic [13:0] thr;
        logic        chk;
        logic        ld;
        logic [13:0] a;
        logic        fv;
        logic [14:0] feat;
        logic        fovf;
        logic        busy;
    } vec_t;

    vec_t  vecs[$];
    string cur_tag;
    int    cur_thr;
    int    cur_feat;
    logic  cur_fovf;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic push(input logic r, input logic v, input int s,
                        input logic ld, input int a, input logic fv, input logic by);
        vec_t t;
        t.tag  = cur_tag;
        t.rst  = r;
        t.v    = v;
        t.s    = 14'(s);
        t.thr  = 14'(cur_thr);
        t.chk  = 1'b1;
        t.ld   = ld;
        t.a    = 14'(a);
        t.fv   = fv;
        t.feat = 15'(cur_feat);
        t.fovf = cur_fovf;
        t.busy = by;
        vecs.push_back(t);
    endtask

    // Strobe followed by the holdoff tail (busy for 3 more cycles, then idle).
    task automatic push_tail();
        push(0, 1, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) push(0, 1, 0, 0, 0, 0, 1);
        push(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit got;

        cur_tag = "reset"; cur_thr = 100; cur_feat = 0; cur_fovf = 1'b0;
        push(1, 0, 0, 0, 0, 0, 0);
        vecs[0].chk = 1'b0;
        push(1, 0, 0, 0, 0, 0, 0);

        cur_tag = "basic";
        push(0, 1, 0,   0, 0,   0, 0);
        push(0, 1, 50,  0, 0,   0, 0);
        push(0, 1, 120, 0, 0,   0, 0);
        push(0, 1, 130, 1, 120, 0, 1);
        push(0, 1, -7,  0, 130, 0, 1);
        push(0, 1, 2,   0, -7,  0, 1);
        push(0, 1, 3,   0, 2,   0, 1);
        push(0, 1, 8,   0, 3,   0, 1);
        push(0, 1, 10,  0, 8,   0, 1);
        push(0, 1, 20,  0, 10,  0, 1);
        push(0, 1, 0,   0, 20,  0, 1);
        push(0, 1, 0,   0, 0,   0, 1);
        cur_feat = 286;
        push_tail();

        cur_tag = "gapped";
        push(0, 1, 0,   0, 0,   0, 0);
        push(0, 1, 50,  0, 0,   0, 0);
        push(0, 1, 120, 0, 0,   0, 0);
        push(0, 1, 130, 1, 120, 0, 1);
        push(0, 0, 500, 0, 130, 0, 1);
        push(0, 0, 500, 0, 0,   0, 1);
        push(0, 1, -7,  0, 0,   0, 1);
        push(0, 1, 2,   0, -7,  0, 1);
        push(0, 1, 3,   0, 2,   0, 1);
        push(0, 1, 8,   0, 3,   0, 1);
        push(0, 1, 10,  0, 8,   0, 1);
        push(0, 1, 20,  0, 10,  0, 1);
        push(0, 1, 0,   0, 20,  0, 1);
        push(0, 1, 0,   0, 0,   0, 1);
        push_tail();

        cur_tag = "overflow"; cur_thr = 0;
        push(0, 1, -5,   0, 0,    0, 0);
        push(0, 1, 8190, 0, 0,    0, 0);
        push(0, 1, 8190, 1, 8190, 0, 1);
        for (int k = 0; k < 6; k++) push(0, 1, 8190, 0, 8190, 0, 1);
        push(0, 1, 0,    0, 8190, 0, 1);
        push(0, 1, 0,    0, 0,    0, 1);
        cur_feat = -16; cur_fovf = 1'b1;
        push_tail();

        cur_tag = "holdoff"; cur_thr = 100;
        push(0, 1, -10, 0, 0,   0, 0);
        push(0, 1, 150, 0, 0,   0, 0);
        push(0, 1, 1,   1, 150, 0, 1);
        for (int k = 0; k < 6; k++) push(0, 1, 1, 0, 1, 0, 1);
        push(0, 1, 0,   0, 1,   0, 1);
        push(0, 1, 0,   0, 0,   0, 1);
        cur_feat = 157; cur_fovf = 1'b0;
        push(0, 1, 0,   0, 0,   1, 1);
        push(0, 1, -10, 0, 0,   0, 1);
        push(0, 1, 150, 0, 0,   0, 1);
        push(0, 1, 0,   0, 0,   0, 1);
        push(0, 1, 0,   0, 0,   0, 0);
        push(0, 1, -10, 0, 0,   0, 0);
        push(0, 1, 150, 0, 0,   0, 0);
        push(0, 1, 2,   1, 150, 0, 1);
        for (int k = 0; k < 6; k++) push(0, 1, 2, 0, 2, 0, 1);
        push(0, 1, 0,   0, 2,   0, 1);
        push(0, 1, 0,   0, 0,   0, 1);
        cur_feat = 164;
        push_tail();

        cur_tag = "reset_above";
        push(1, 1, 200, 0, 0,   0, 0);
        cur_feat = 0;
        for (int k = 0; k < 3; k++) push(0, 1, 200, 0, 0, 0, 0);
        push(0, 1, 50,  0, 0,   0, 0);
        push(0, 1, 200, 0, 0,   0, 0);
        cur_tag = "mid_reset";
        push(0, 1, 10,  1, 200, 0, 1);
        push(0, 1, 20,  0, 10,  0, 1);
        push(1, 1, 30,  0, 20,  0, 1);
        push(0, 1, 50,  0, 0,   0, 0);
        push(0, 1, 200, 0, 0,   0, 0);
        push(0, 1, 3,   1, 200, 0, 1);
        for (int k = 0; k < 6; k++) push(0, 1, 3, 0, 3, 0, 1);
        push(0, 1, 0,   0, 3,   0, 1);
        push(0, 1, 0,   0, 0,   0, 1);
        cur_feat = 221;
        push_tail();

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            if (vecs[i].chk) begin
                n_vec++;
                if (acc_load !== vecs[i].ld || acc_a !== vecs[i].a ||
                    feature_valid !== vecs[i].fv || feature !== vecs[i].feat ||
                    feature_overflow !== vecs[i].fovf || busy !== vecs[i].busy) begin
                    n_err++;
                    $display("FAIL %s row %0d: got load=%b a=%0d fv=%b feature=%0d fovf=%b busy=%b, want load=%b a=%0d fv=%b feature=%0d fovf=%b busy=%b",
                             vecs[i].tag, i, acc_load, $signed(acc_a), feature_valid,
                             $signed(feature), feature_overflow, busy, vecs[i].ld,
                             $signed(vecs[i].a), vecs[i].fv, $signed(vecs[i].feat),
                             vecs[i].fovf, vecs[i].busy);
                end
            end
            reset        = vecs[i].rst;
            sample_valid = vecs[i].v;
            sample       = vecs[i].s;
            threshold    = vecs[i].thr;
        end

        // Alternating-valid window: 101 then seven samples of -1 with invalid gaps.
        @(posedge clk); #1;
        sample_valid = 1'b1; sample = 14'd101;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            sample_valid = 1'b0; sample = 14'd5000;
            @(posedge clk); #1;
            sample_valid = 1'b1; sample = -14'sd1;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0; sample = '0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (feature_valid === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_vec++;
        if (!got || feature !== 15'd94 || feature_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL alternating: got strobe=%b feature=%0d fovf=%b, want strobe=1 feature=94 fovf=0",
                     got, $signed(feature), feature_overflow);
        end

        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (n_pulse != 7) begin
            n_err++;
            $display("FAIL strobe_count: got %0d feature_valid cycles, want 7", n_pulse);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
